pcileech_rst_ctl: RTL and testbench

//  Reset front-end that sits directly upstream of the board top-level logic.
//  It turns the PLL-locked reset, the raw reset push-button and raw PCIe PERST# into clean, synchronous signals:
//   - system reset rst for pcileech_com, pcileech_fifo and pcileech_pcie_a7;
//   - ft601_rst_n for the FT601 pads;
//   - synchronised perst_n_sync.

---
 rtl/pcileech_rst_ctl_if.sv | 29 ++
 rtl/pcileech_rst_ctl.sv | 154 +++++++++++++++
 tb/tb_pcileech_rst_ctl.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/pcileech_rst_ctl_if.sv
// Reset front-end signal bundle: raw reset sources in, conditioned resets out.
// The board logic drives the raw inputs (master); the reset controller is the slave.
`timescale 1ns/1ps
interface pcileech_rst_ctl_if;
    logic       btn_rst;
    logic       pcie_perst_n;
    logic       rst;
    logic       ft601_rst_n;
    logic       perst_n_sync;
    logic [7:0] rst_count;

    modport master (
        output btn_rst,
        output pcie_perst_n,
        input  rst,
        input  ft601_rst_n,
        input  perst_n_sync,
        input  rst_count
    );

    modport slave (
        input  btn_rst,
        input  pcie_perst_n,
        output rst,
        output ft601_rst_n,
        output perst_n_sync,
        output rst_count
    );
endinterface

// File: rtl/pcileech_rst_ctl.sv
// Reset front-end: synchronises PLL-locked reset, debounces the reset button,
// synchronises PERST# and holds the system reset for POR_CYCLES after every cause clears.
`timescale 1ns/1ps
module pcileech_rst_ctl #(
    parameter int POR_CYCLES      = 64,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    pcileech_rst_ctl_if.slave   bus_if
);
    localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(POR_CYCLES);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(POR_CYCLES - 1);

    typedef enum logic [0:0] {
        S_HOLD = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    logic [1:0]        rst_sync_q;
    logic              run_s;
    logic              btn_meta_q;
    logic              btn_s_q;
    logic              perst_meta_q;
    logic              perst_sync_q;
    logic [DEB_W-1:0]  deb_cnt_q;
    logic [DEB_W-1:0]  deb_cnt_d;
    logic              btn_stable_q;
    logic              btn_stable_d;
    logic              btn_prev_q;
    state_e            state_q;
    logic [HOLD_W-1:0] hold_cnt_q;
    logic              rst_q;
    logic              ft601_rst_n_q;
    logic [7:0]        rst_count_q;

    // Reset release synchroniser: internal logic leaves reset two edges after rst_ni rises.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign run_s = rst_sync_q[1];

    // Two-flop synchronisers for the raw button and PERST# pins.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            btn_meta_q   <= 1'b0;
            btn_s_q      <= 1'b0;
            perst_meta_q <= 1'b0;
            perst_sync_q <= 1'b0;
        end else begin
            btn_meta_q   <= bus_if.btn_rst;
            btn_s_q      <= btn_meta_q;
            perst_meta_q <= bus_if.pcie_perst_n;
            perst_sync_q <= perst_meta_q;
        end
    end

    // Debounce next state: a change is accepted after DEBOUNCE_CYCLES consecutive differing samples.
    always_comb begin
        deb_cnt_d    = deb_cnt_q;
        btn_stable_d = btn_stable_q;
        if (btn_s_q == btn_stable_q) begin
            deb_cnt_d = {DEB_W{1'b0}};
        end else if (deb_cnt_q == DEB_LAST) begin
            deb_cnt_d    = {DEB_W{1'b0}};
            btn_stable_d = btn_s_q;
        end else begin
            deb_cnt_d = deb_cnt_q + DEB_W'(1);
        end
    end

    // Debounce registers, held cleared until the internal reset releases.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            deb_cnt_q    <= {DEB_W{1'b0}};
            btn_stable_q <= 1'b0;
        end else if (!run_s) begin
            deb_cnt_q    <= {DEB_W{1'b0}};
            btn_stable_q <= 1'b0;
        end else begin
            deb_cnt_q    <= deb_cnt_d;
            btn_stable_q <= btn_stable_d;
        end
    end

    // Hold/run FSM with registered reset outputs; a held button keeps restarting the hold.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= S_HOLD;
            hold_cnt_q    <= {HOLD_W{1'b0}};
            btn_prev_q    <= 1'b0;
            rst_q         <= 1'b1;
            ft601_rst_n_q <= 1'b0;
            rst_count_q   <= 8'd0;
        end else if (!run_s) begin
            state_q       <= S_HOLD;
            hold_cnt_q    <= {HOLD_W{1'b0}};
            btn_prev_q    <= 1'b0;
            rst_q         <= 1'b1;
            ft601_rst_n_q <= 1'b0;
            rst_count_q   <= 8'd0;
        end else begin
            btn_prev_q <= btn_stable_q;
            case (state_q)
                S_HOLD: begin
                    if (btn_stable_q) begin
                        hold_cnt_q <= {HOLD_W{1'b0}};
                    end else if (hold_cnt_q == HOLD_LAST) begin
                        state_q       <= S_RUN;
                        hold_cnt_q    <= {HOLD_W{1'b0}};
                        rst_q         <= 1'b0;
                        ft601_rst_n_q <= 1'b1;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
                    end
                end
                S_RUN: begin
                    // Only a fresh press in run counts; presses during a hold merely extend it.
                    if (btn_stable_q && !btn_prev_q) begin
                        state_q       <= S_HOLD;
                        hold_cnt_q    <= {HOLD_W{1'b0}};
                        rst_q         <= 1'b1;
                        ft601_rst_n_q <= 1'b0;
                        if (rst_count_q != 8'hFF) begin
                            rst_count_q <= rst_count_q + 8'd1;
                        end else begin
                            rst_count_q <= rst_count_q;
                        end
                    end else begin
                        state_q <= S_RUN;
                    end
                end
                default: begin
                    state_q       <= S_HOLD;
                    hold_cnt_q    <= {HOLD_W{1'b0}};
                    rst_q         <= 1'b1;
                    ft601_rst_n_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus_if.rst          = rst_q;
    assign bus_if.ft601_rst_n  = ft601_rst_n_q;
    assign bus_if.perst_n_sync = perst_sync_q;
    assign bus_if.rst_count    = rst_count_q;
endmodule

// File: tb/tb_pcileech_rst_ctl.sv
// Bench for pcileech_rst_ctl (POR_CYCLES=64, DEBOUNCE_CYCLES=8): directed stimulus,
// a history-based reference model compared every cycle, plus literal checkpoints.
`timescale 1ns/1ps
module tb_pcileech_rst_ctl;
    localparam int POR = 64;
    localparam int DEB = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    pcileech_rst_ctl_if bus_if ();

    pcileech_rst_ctl #(.POR_CYCLES(POR), .DEBOUNCE_CYCLES(DEB)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus_if (bus_if.slave)
    );

    always #5 clk = ~clk;

    // Reference model state (reset values)
    int ecnt    = 0;
    bit m_rst   = 1'b1;
    int m_quiet = 0;
    int m_cnt   = 0;
    bit m_stable = 1'b0;
    bit m_prev  = 1'b0;
    bit btn_h[$];
    bit per_h[$];
    bit win[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Model: the system leaves reset on the third edge after release; the button is
    // accepted once its synchronised value has disagreed for the last DEB running edges;
    // reset ends after POR running edges with no accepted press.
    initial forever begin
        bit bs;
        bit run;
        bit all_diff;
        bit st;
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            ecnt = 0; m_rst = 1'b1; m_quiet = 0; m_cnt = 0;
            m_stable = 1'b0; m_prev = 1'b0;
            btn_h.delete(); per_h.delete(); win.delete();
        end else begin
            run = (ecnt >= 2);
            if (ecnt < 1000) ecnt++;
            bs = (btn_h.size() >= 2) ? btn_h[btn_h.size()-2] : 1'b0;
            btn_h.push_back(bus_if.btn_rst);
            per_h.push_back(bus_if.pcie_perst_n);
            if (btn_h.size() > 3) void'(btn_h.pop_front());
            if (per_h.size() > 3) void'(per_h.pop_front());
            if (run) begin
                st = m_stable;
                if (m_rst) begin
                    if (st) m_quiet = 0;
                    else begin
                        m_quiet++;
                        if (m_quiet == POR) begin m_rst = 1'b0; m_quiet = 0; end
                    end
                end else if (st && !m_prev) begin
                    m_rst = 1'b1; m_quiet = 0;
                    if (m_cnt < 255) m_cnt++;
                end
                win.push_back(bs);
                if (win.size() > DEB) void'(win.pop_front());
                all_diff = (win.size() == DEB);
                foreach (win[i]) if (win[i] == st) all_diff = 1'b0;
                m_prev = st;
                if (all_diff) m_stable = bs;
            end
        end
    end

    // Per-cycle comparison against the model on the falling edge.
    initial forever begin
        @(negedge clk);
        chk("rst", bus_if.rst, m_rst);
        chk("ft601_rst_n", bus_if.ft601_rst_n, !m_rst);
        chk("perst_n_sync", bus_if.perst_n_sync, (per_h.size() >= 2) ? per_h[per_h.size()-2] : 1'b0);
        chk("rst_count", bus_if.rst_count, m_cnt);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic lit(input string name, input logic [31:0] dut_v, input logic [31:0] mdl_v, input logic [31:0] exp);
        chk({name, "_dut"}, dut_v, exp);
        chk({name, "_model"}, mdl_v, exp);
    endtask

    initial begin
        bus_if.btn_rst      = 1'b0;
        bus_if.pcie_perst_n = 1'b1;
        tick(3);
        lit("reset_rst", bus_if.rst, m_rst, 1);
        lit("reset_count", bus_if.rst_count, m_cnt, 0);
        chk("reset_perst", bus_if.perst_n_sync, 0);

        // 1: power-on hold
        rst_n = 1'b1;
        tick(1);
        chk("por_perst_1", bus_if.perst_n_sync, 0);
        tick(1);
        chk("por_perst_2", bus_if.perst_n_sync, 1);
        tick(63);
        lit("por_hold_last", bus_if.rst, m_rst, 1);
        chk("por_ft601_last", bus_if.ft601_rst_n, 0);
        tick(1);
        lit("por_release", bus_if.rst, m_rst, 0);
        chk("por_ft601_rel", bus_if.ft601_rst_n, 1);

        // 2: 20-cycle press
        bus_if.btn_rst = 1'b1;
        tick(10);
        lit("press_pre", bus_if.rst, m_rst, 0);
        tick(1);
        lit("press_rst", bus_if.rst, m_rst, 1);
        lit("press_count", bus_if.rst_count, m_cnt, 1);
        tick(9);
        bus_if.btn_rst = 1'b0;
        tick(73);
        lit("press_hold_last", bus_if.rst, m_rst, 1);
        tick(1);
        lit("press_release", bus_if.rst, m_rst, 0);

        // 3: glitches shorter than the debounce window
        bus_if.btn_rst = 1'b1; tick(3);
        bus_if.btn_rst = 1'b0; tick(2);
        bus_if.btn_rst = 1'b1; tick(5);
        bus_if.btn_rst = 1'b0; tick(2);
        bus_if.btn_rst = 1'b1; tick(7);
        bus_if.btn_rst = 1'b0; tick(20);
        lit("glitch_rst", bus_if.rst, m_rst, 0);
        lit("glitch_count", bus_if.rst_count, m_cnt, 1);

        // 4: 299 more presses -> saturation
        for (int i = 0; i < 299; i++) begin
            bus_if.btn_rst = 1'b1; tick(12);
            bus_if.btn_rst = 1'b0; tick(90);
        end
        lit("sat_count", bus_if.rst_count, m_cnt, 255);
        lit("sat_rst", bus_if.rst, m_rst, 0);

        // 5: async reset mid-run with button held through release
        bus_if.btn_rst = 1'b1;
        rst_n = 1'b0;
        #1;
        lit("async_rst", bus_if.rst, m_rst, 1);
        lit("async_count", bus_if.rst_count, m_cnt, 0);
        chk("async_ft601", bus_if.ft601_rst_n, 0);
        tick(1);
        rst_n = 1'b1;
        tick(40);
        lit("held_rst", bus_if.rst, m_rst, 1);
        bus_if.btn_rst = 1'b0;
        tick(73);
        lit("held_hold_last", bus_if.rst, m_rst, 1);
        tick(1);
        lit("held_release", bus_if.rst, m_rst, 0);
        lit("held_count", bus_if.rst_count, m_cnt, 0);

        // 6: PERST# toggles
        bus_if.pcie_perst_n = 1'b0;
        tick(1);
        chk("perst_fall_1", bus_if.perst_n_sync, 1);
        tick(1);
        chk("perst_fall_2", bus_if.perst_n_sync, 0);
        tick(3);
        bus_if.pcie_perst_n = 1'b1;
        tick(2);
        chk("perst_rise", bus_if.perst_n_sync, 1);
        tick(3);
        bus_if.pcie_perst_n = 1'b0;
        tick(2);
        chk("perst_fall_again", bus_if.perst_n_sync, 0);
        tick(5);
        lit("perst_rst", bus_if.rst, m_rst, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
